// File: rtl/timer_counter.sv
// Down-counting bus timer: CTRL/PRESET/COUNT register file with a one-shot or
// periodic interrupt. Synchronous active-low reset, all state on posedge clk.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for CTRL.Enable
//  LOAD  | COUNT <= PRESET
//  CNT   | decrement COUNT each cycle until it reaches 0
//  INT   | terminal count: raise irq_flag, then reload or stop
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    logic [1:0]  state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic        wr_ctrl;
    logic        wr_preset;

    assign ctrl_en   = ctrl[0];
    assign ctrl_mode = ctrl[2:1];
    assign ctrl_im   = ctrl[3];

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_preset = we && (addr == A_PRESET);

    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_CTRL:   rdata = {28'd0, ctrl};
            A_PRESET: rdata = preset;
            A_COUNT:  rdata = count;
            default:  rdata = 32'd0;
        endcase
    end

    assign irq = ctrl_im & irq_flag;

    // CPU writes are applied after the FSM updates so that a CTRL write on the
    // same edge as the hardware Enable clear takes precedence.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_en) begin
                        state <= ST_IDLE;
                    end else if (count <= 32'd1) begin
                        count    <= 32'd0;
                        irq_flag <= 1'b1;
                        state    <= ST_INT;
                    end else begin
                        count <= count - 32'd1;
                    end
                end
                ST_INT: begin
                    if (ctrl_mode == MODE_PERIODIC) begin
                        irq_flag <= 1'b0;
                        state    <= ST_LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (wr_ctrl) begin
                ctrl     <= wdata[3:0];
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed scenarios followed by randomized bus traffic, each cycle compared
// against a cycle-level behavioural model of the timer.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // model: phase names are plain ints, counts are plain integers
    localparam int PH_IDLE = 100;
    localparam int PH_LOAD = 200;
    localparam int PH_RUN  = 300;
    localparam int PH_TC   = 400;

    int          m_phase = PH_IDLE;
    logic [3:0]  m_ctrl = 4'd0;
    longint      m_pre = 0;
    longint      m_cnt = 0;
    bit          m_flag = 1'b0;

    logic [31:0] obs_ctrl, obs_pre, obs_cnt, obs_a3;
    logic        obs_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
        int         ph;
        logic [3:0] c;
        longint     p, n;
        bit         f;
        ph = m_phase; c = m_ctrl; p = m_pre; n = m_cnt; f = m_flag;
        if (!r) begin
            ph = PH_IDLE; c = 4'd0; p = 0; n = 0; f = 1'b0;
        end else begin
            if (m_phase == PH_IDLE && m_ctrl[0]) ph = PH_LOAD;
            if (m_phase == PH_LOAD) begin n = m_pre; ph = PH_RUN; end
            if (m_phase == PH_RUN) begin
                if (!m_ctrl[0]) ph = PH_IDLE;
                else if (m_cnt <= 1) begin n = 0; f = 1'b1; ph = PH_TC; end
                else n = m_cnt - 1;
            end
            if (m_phase == PH_TC) begin
                if (m_ctrl[2:1] == 2'd1) begin f = 1'b0; ph = PH_LOAD; end
                else begin c[0] = 1'b0; ph = PH_IDLE; end
            end
            if (w && a == 2'd0) begin c = d[3:0]; f = 1'b0; end
            if (w && a == 2'd1) p = longint'(d);
        end
        m_phase = ph; m_ctrl = c; m_pre = p; m_cnt = n; m_flag = f;
    endtask

    // one clock edge with the given bus/reset inputs, then read back everything
    task automatic step(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
        reset = r; addr = a; we = w; wdata = d;
        model_edge(r, a, w, d);
        @(posedge clk);
        #1;
        reset = 1'b1; we = 1'b0;
        addr = 2'd0; #1; obs_ctrl = rdata;
        addr = 2'd1; #1; obs_pre = rdata;
        addr = 2'd2; #1; obs_cnt = rdata;
        addr = 2'd3; #1; obs_a3 = rdata;
        obs_irq = irq;
        chk("model_ctrl", obs_ctrl, {28'd0, m_ctrl});
        chk("model_preset", obs_pre, m_pre[31:0]);
        chk("model_count", obs_cnt, m_cnt[31:0]);
        chk("model_addr3", obs_a3, 32'd0);
        chk("model_irq", {31'd0, obs_irq}, {31'd0, m_ctrl[3] & m_flag});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'd3, 1'b0, 32'd0);
    endtask

    initial begin
        // reset state, with a write attempted during reset
        step(1'b0, 2'd1, 1'b1, 32'h1234);
        chk("rst_ctrl", obs_ctrl, 32'd0);
        chk("rst_preset", obs_pre, 32'd0);
        chk("rst_count", obs_cnt, 32'd0);
        chk("rst_irq", {31'd0, obs_irq}, 32'd0);

        // one-shot, PRESET=3, CTRL=0x9 at edge k
        step(1'b1, 2'd1, 1'b1, 32'd3);
        step(1'b1, 2'd0, 1'b1, 32'h9);           // k
        idle(1);                                 // k+1 LOAD
        idle(1); chk("os_cnt_k2", obs_cnt, 32'd3);
        idle(1); chk("os_cnt_k3", obs_cnt, 32'd2);
        idle(1); chk("os_cnt_k4", obs_cnt, 32'd1);
        chk("os_irq_k4", {31'd0, obs_irq}, 32'd0);
        idle(1); chk("os_cnt_k5", obs_cnt, 32'd0);
        chk("os_irq_k5", {31'd0, obs_irq}, 32'd1);
        idle(1); chk("os_ctrl_k6", obs_ctrl, 32'h8);
        chk("os_irq_k6", {31'd0, obs_irq}, 32'd1);
        idle(3); chk("os_irq_hold", {31'd0, obs_irq}, 32'd1);
        step(1'b1, 2'd0, 1'b1, 32'h0);
        chk("os_irq_clr", {31'd0, obs_irq}, 32'd0);

        // periodic, PRESET=2, CTRL=0xB: irq at k+4, k+8, k+12
        step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b1, 2'd1, 1'b1, 32'd2);
        step(1'b1, 2'd0, 1'b1, 32'hB);           // k
        for (int i = 1; i <= 12; i++) begin
            idle(1);
            chk($sformatf("per_irq_k%0d", i), {31'd0, obs_irq}, {31'd0, (i % 4) == 0});
        end
        step(1'b1, 2'd0, 1'b1, 32'h0);

        // masked interrupt, PRESET=1, CTRL=0x1
        step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b1, 2'd1, 1'b1, 32'd1);
        step(1'b1, 2'd0, 1'b1, 32'h1);
        idle(4);
        chk("mask_count", obs_cnt, 32'd0);
        chk("mask_ctrl", obs_ctrl, 32'd0);
        chk("mask_irq", {31'd0, obs_irq}, 32'd0);
        step(1'b1, 2'd0, 1'b1, 32'h8);
        chk("mask_irq_after_im", {31'd0, obs_irq}, 32'd0);

        // pause at COUNT=5, then new PRESET reloads
        step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b1, 2'd1, 1'b1, 32'd9);
        step(1'b1, 2'd0, 1'b1, 32'h1);           // k
        idle(5);                                 // COUNT=6 after k+5
        chk("pause_pre6", obs_cnt, 32'd6);
        step(1'b1, 2'd0, 1'b1, 32'h0);           // 6 -> 5 on this edge, Enable off
        idle(4);
        chk("pause_hold", obs_cnt, 32'd5);
        step(1'b1, 2'd1, 1'b1, 32'd7);
        chk("pause_preset_no_effect", obs_cnt, 32'd5);
        step(1'b1, 2'd0, 1'b1, 32'h1);
        idle(2);
        chk("pause_reload", obs_cnt, 32'd7);
        step(1'b1, 2'd0, 1'b1, 32'h0);

        // reset mid-count at COUNT=4
        step(1'b0, 2'd3, 1'b0, 32'd0);
        step(1'b1, 2'd1, 1'b1, 32'd8);
        step(1'b1, 2'd0, 1'b1, 32'h9);
        idle(6);
        chk("mid_cnt4", obs_cnt, 32'd4);
        step(1'b0, 2'd0, 1'b1, 32'hF);
        chk("mid_rst_ctrl", obs_ctrl, 32'd0);
        chk("mid_rst_preset", obs_pre, 32'd0);
        chk("mid_rst_count", obs_cnt, 32'd0);
        idle(12);
        chk("mid_no_int", {31'd0, obs_irq}, 32'd0);

        // PRESET=0 boundary, COUNT write ignored, addr 3
        step(1'b1, 2'd0, 1'b1, 32'h9);           // k
        idle(2);
        chk("p0_irq_k2", {31'd0, obs_irq}, 32'd0);
        idle(1);
        chk("p0_irq_k3", {31'd0, obs_irq}, 32'd1);
        step(1'b1, 2'd2, 1'b1, 32'h55);
        chk("count_wr_ignored", obs_cnt, 32'd0);
        step(1'b1, 2'd3, 1'b1, 32'hFFFF_FFFF);
        chk("addr3_read", obs_a3, 32'd0);
        chk("ctrl_upper_zero", obs_ctrl & 32'hFFFF_FFF0, 32'd0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            int          sel;
            logic [31:0] d;
            sel = int'($urandom_range(0, 99));
            if (sel < 3) begin
                step(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
            end else if (sel < 13) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                step(1'b1, 2'd0, 1'b1, d);
            end else if (sel < 20) begin
                step(1'b1, 2'd1, 1'b1, 32'($urandom_range(0, 6)));
            end else if (sel < 24) begin
                step(1'b1, 2'($urandom_range(2, 3)), 1'b1, $urandom);
            end else begin
                step(1'b1, 2'($urandom_range(0, 3)), 1'b0, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
